// File: rtl/ste_audio_pkg.sv
// Shared constants, register ids and the attenuation-step LUT for the STE
// LMC1992 volume/tone emulation.
package ste_audio_pkg;

    localparam logic [2:0] ID_MIX    = 3'd0;
    localparam logic [2:0] ID_BASS   = 3'd1;
    localparam logic [2:0] ID_TREBLE = 3'd2;
    localparam logic [2:0] ID_MASTER = 3'd3;
    localparam logic [2:0] ID_RIGHT  = 3'd4;
    localparam logic [2:0] ID_LEFT   = 3'd5;

    typedef enum logic [1:0] {
        MIX_QUARTER = 2'b00,
        MIX_FULL    = 2'b01,
        MIX_OFF     = 2'b10,
        MIX_OFF_ALT = 2'b11
    } mix_e;

    localparam mix_e       MIX_RST    = MIX_FULL;
    localparam logic [5:0] MASTER_RST = 6'd40;
    localparam logic [5:0] SIDE_RST   = 6'd20;
    localparam logic [3:0] TONE_RST   = 4'd6;

    localparam logic [3:0] TONE_MAX   = 4'd12;
    localparam logic [5:0] SIDE_MAX   = 6'd20;
    localparam logic [5:0] MASTER_MAX = 6'd40;

    localparam logic [8:0] MANT_0 = 9'd256;
    localparam logic [8:0] MANT_1 = 9'd203;
    localparam logic [8:0] MANT_2 = 9'd161;

    localparam int STEPS = 61;

    typedef struct packed {
        logic [8:0] mant;
        logic [4:0] sh;
    } gain_t;

    function automatic logic [5:0] clamp_lvl(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [3:0] clamp_tone(input logic [3:0] v);
        return (v > TONE_MAX) ? TONE_MAX : v;
    endfunction

    // Each 2 dB step is a factor of ~0.794; three steps make one binary shift.
    // Steps past the table end map to a shift that mutes the output.
    function automatic gain_t step_gain(input logic [5:0] step);
        gain_t g;
        g.mant = MANT_0;
        g.sh   = 5'd21;
        for (int i = 0; i < STEPS; i++) begin
            if (step == 6'(i)) begin
                case (i % 3)
                    0:       g.mant = MANT_0;
                    1:       g.mant = MANT_1;
                    default: g.mant = MANT_2;
                endcase
                g.sh = 5'(i / 3);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ste_mw_rx.sv
// Microwire frame receiver: masked serial shift-in, bit count, frame-end edge
// detection and frame validation.
module ste_mw_rx
    import ste_audio_pkg::*;
#(
    parameter int MW_BITS = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mw_strobe,
    input  logic       mw_clk,
    input  logic       mw_data,
    input  logic       mw_done,
    output logic       wr_stb,
    output logic [2:0] wr_id,
    output logic [5:0] wr_data,
    output logic       cmd_err
);

    logic [MW_BITS-1:0] shift_q, shift_d, shift_in;
    logic [3:0]         cnt_q, cnt_d, cnt_in;
    logic               done_q;
    logic               cmd_err_q, cmd_err_d;
    logic               bit_vld, done_rise, frame_ok;

    // A bit presented in the same cycle as the frame end still counts.
    always_comb begin
        bit_vld  = mw_strobe & mw_clk;
        shift_in = shift_q;
        cnt_in   = cnt_q;
        if (bit_vld) begin
            shift_in = {shift_q[MW_BITS-2:0], mw_data};
            if (cnt_q != 4'hF) begin
                cnt_in = cnt_q + 4'd1;
            end
        end
        done_rise = mw_done & ~done_q;
        frame_ok  = (cnt_in == 4'(MW_BITS)) && (shift_in[MW_BITS-1 -: 2] == 2'b10);
        shift_d   = done_rise ? '0 : shift_in;
        cnt_d     = done_rise ? '0 : cnt_in;
        cmd_err_d = done_rise & ~frame_ok;
        wr_stb    = done_rise & frame_ok;
        wr_id     = shift_in[8:6];
        wr_data   = shift_in[5:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            done_q    <= mw_done;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign cmd_err = cmd_err_q;

endmodule

// File: rtl/ste_lmc1992.sv
// STE LMC1992 emulation: control registers, per-side de-zipper gain ramp and
// a 3-stage mix/attenuate datapath producing signed 16-bit stereo.
module ste_lmc1992
    import ste_audio_pkg::*;
#(
    parameter int MW_BITS = 11,
    parameter int RAMP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mw_strobe,
    input  logic               mw_clk,
    input  logic               mw_data,
    input  logic               mw_done,
    input  logic               sample_en,
    input  logic [7:0]         ste_l,
    input  logic [7:0]         ste_r,
    input  logic [7:0]         psg,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               out_valid,
    output logic [3:0]         bass,
    output logic [3:0]         treble,
    output logic               cmd_err
);

    logic       wr_stb;
    logic [2:0] wr_id;
    logic [5:0] wr_data;

    ste_mw_rx #(.MW_BITS(MW_BITS)) u_mw_rx (
        .clk       (clk),
        .reset     (reset),
        .mw_strobe (mw_strobe),
        .mw_clk    (mw_clk),
        .mw_data   (mw_data),
        .mw_done   (mw_done),
        .wr_stb    (wr_stb),
        .wr_id     (wr_id),
        .wr_data   (wr_data),
        .cmd_err   (cmd_err)
    );

    mix_e       mix_q, mix_d;
    logic [3:0] bass_q, bass_d, treble_q, treble_d;
    logic [5:0] master_q, master_d, left_q, left_d, right_q, right_d;

    always_comb begin
        mix_d    = mix_q;
        bass_d   = bass_q;
        treble_d = treble_q;
        master_d = master_q;
        left_d   = left_q;
        right_d  = right_q;
        if (wr_stb) begin
            case (wr_id)
                ID_MIX:    mix_d    = mix_e'(wr_data[1:0]);
                ID_BASS:   bass_d   = clamp_tone(wr_data[3:0]);
                ID_TREBLE: treble_d = clamp_tone(wr_data[3:0]);
                ID_MASTER: master_d = clamp_lvl(wr_data, MASTER_MAX);
                ID_RIGHT:  right_d  = clamp_lvl(wr_data, SIDE_MAX);
                ID_LEFT:   left_d   = clamp_lvl(wr_data, SIDE_MAX);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_q    <= MIX_RST;
            bass_q   <= TONE_RST;
            treble_q <= TONE_RST;
            master_q <= MASTER_RST;
            left_q   <= SIDE_RST;
            right_q  <= SIDE_RST;
        end else begin
            mix_q    <= mix_d;
            bass_q   <= bass_d;
            treble_q <= treble_d;
            master_q <= master_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign bass   = bass_q;
    assign treble = treble_q;

    // PSG contribution is common to both sides.
    logic signed [7:0] p_s;
    logic signed [9:0] p_ext, p_term;

    always_comb begin
        p_s   = signed'(psg ^ 8'h80);
        p_ext = {{2{p_s[7]}}, p_s};
        case (mix_q)
            MIX_QUARTER: p_term = p_ext >>> 2;
            MIX_FULL:    p_term = p_ext;
            default:     p_term = '0;
        endcase
    end

    logic v1_q, v2_q, v3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= sample_en;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    assign out_valid = v3_q;

    logic [1:0][7:0]  ste_w;
    logic [1:0][5:0]  side_w;
    logic [1:0][15:0] out_w;

    assign ste_w  = {ste_r, ste_l};
    assign side_w = {right_q, left_q};

    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        logic [5:0]         cur_q, cur_d, tgt, cur1_q;
        logic signed [7:0]  s_s;
        logic signed [9:0]  s_ext, m_d, m1_q;
        logic signed [18:0] prod_d, prod_q;
        logic [4:0]         sh_q;
        logic signed [15:0] out_d, out_q;
        gain_t              g1;

        assign tgt = (MASTER_MAX - master_q) + (SIDE_MAX - side_w[gi]);

        // The ramp sees the target as it stood before any same-cycle write.
        always_comb begin
            cur_d = cur_q;
            if (sample_en) begin
                if (RAMP == 0) begin
                    cur_d = tgt;
                end else if (cur_q < tgt) begin
                    cur_d = cur_q + 6'd1;
                end else if (cur_q > tgt) begin
                    cur_d = cur_q - 6'd1;
                end
            end
        end

        always_comb begin
            s_s    = signed'(ste_w[gi] ^ 8'h80);
            s_ext  = {{2{s_s[7]}}, s_s};
            m_d    = (s_ext <<< 1) + p_term;
            g1     = step_gain(cur1_q);
            prod_d = m1_q * $signed({1'b0, g1.mant});
            out_d  = (sh_q >= 5'd16) ? '0 : 16'(prod_q >>> ({1'b0, sh_q} + 6'd2));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cur_q  <= '0;
                cur1_q <= '0;
                m1_q   <= '0;
                prod_q <= '0;
                sh_q   <= '0;
                out_q  <= '0;
            end else begin
                cur_q <= cur_d;
                if (sample_en) begin
                    cur1_q <= cur_d;
                    m1_q   <= m_d;
                end
                if (v1_q) begin
                    prod_q <= prod_d;
                    sh_q   <= g1.sh;
                end
                if (v2_q) begin
                    out_q <= out_d;
                end
            end
        end

        assign out_w[gi] = out_q;
    end

    assign out_l = signed'(out_w[0]);
    assign out_r = signed'(out_w[1]);

endmodule
